// File: rtl/bp_be_pkg.sv
// Shared definitions for the backend late-writeback path: entry layout macros,
// default sizing and round-robin index helpers.
`ifndef BP_BE_LATE_WB_MACROS
`define BP_BE_LATE_WB_MACROS

`define BP_BE_LATE_WB_ENTRY_WIDTH(reg_addr_width_mp, data_width_mp) \
  ((reg_addr_width_mp) + (data_width_mp))

`define DECLARE_BP_BE_LATE_WB_ENTRY_S(reg_addr_width_mp, data_width_mp) \
  typedef struct packed { \
    logic [(reg_addr_width_mp)-1:0] rd_addr; \
    logic [(data_width_mp)-1:0]     rd_data; \
  } bp_be_late_wb_entry_s

`endif

package bp_be_pkg;

  localparam int late_wb_num_req_gp        = 2;
  localparam int late_wb_reg_addr_width_gp = 5;
  localparam int late_wb_data_width_gp     = 64;
  localparam int late_wb_fifo_els_gp       = 2;

  // Requester index visited at scan step 'offset' when the scan starts at 'start'
  function automatic int late_wb_rr_scan(input int start, input int offset, input int n);
    return (start + offset) % n;
  endfunction

  function automatic int late_wb_rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO; ready and valid depend only on registered
// pointers, so a dequeue never frees a slot for an enqueue in the same cycle.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp:0] ptr_one_lp = (ptr_w_lp + 1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp:0]   wptr_r, rptr_r;
  logic                full, empty, enq, deq;

  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp])
              && (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]);

  assign ready_o = reset_n_i & ~full;
  assign v_o     = ~empty;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & ~empty;
  assign data_o  = mem[rptr_r[ptr_w_lp-1:0]];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + ptr_one_lp;
      if (deq) rptr_r <= rptr_r + ptr_one_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r[ptr_w_lp-1:0]] <= data_i;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(enq && full));
  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && empty));
`endif

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Shares the integer regfile write port between pipe writeback (always wins) and
// buffered long-latency results drained round-robin; tracks pending late writes.
module bp_be_late_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter int num_req_p        = late_wb_num_req_gp,
  parameter int reg_addr_width_p = late_wb_reg_addr_width_gp,
  parameter int data_width_p     = late_wb_data_width_gp,
  parameter int fifo_els_p       = late_wb_fifo_els_gp
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 pipe_wb_v_i,
  input  logic [reg_addr_width_p-1:0]          pipe_wb_addr_i,
  input  logic [data_width_p-1:0]              pipe_wb_data_i,
  input  logic [num_req_p-1:0]                 req_v_i,
  input  logic [num_req_p*reg_addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]    req_data_i,
  output logic [num_req_p-1:0]                 req_ready_o,
  input  logic                                 alloc_v_i,
  input  logic [reg_addr_width_p-1:0]          alloc_addr_i,
  output logic                                 rf_w_v_o,
  output logic [reg_addr_width_p-1:0]          rf_w_addr_o,
  output logic [data_width_p-1:0]              rf_w_data_o,
  output logic [(1<<reg_addr_width_p)-1:0]     pending_o,
  output logic [num_req_p-1:0]                 req_grant_o
);

  localparam int rr_w_lp        = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int num_regs_lp    = 1 << reg_addr_width_p;
  localparam int entry_width_lp = `BP_BE_LATE_WB_ENTRY_WIDTH(reg_addr_width_p, data_width_p);

  `DECLARE_BP_BE_LATE_WB_ENTRY_S(reg_addr_width_p, data_width_p);

  bp_be_late_wb_entry_s       fifo_head [num_req_p];
  bp_be_late_wb_entry_s       late_entry;
  logic [num_req_p-1:0]       fifo_v, fifo_yumi;
  logic [rr_w_lp-1:0]         rr_r, grant_idx;
  logic                       grant_found, late_v;
  logic [num_regs_lp-1:0]     pending_r, pending_n;

  for (genvar i = 0; i < num_req_p; i++) begin : req_buf
    bp_be_late_wb_entry_s enq_entry;

    assign enq_entry.rd_addr = req_addr_i[i*reg_addr_width_p +: reg_addr_width_p];
    assign enq_entry.rd_data = req_data_i[i*data_width_p +: data_width_p];

    bsg_fifo_1r1w_small #(
      .width_p(entry_width_lp),
      .els_p  (fifo_els_p)
    ) fifo (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .v_i      (req_v_i[i]),
      .data_i   (enq_entry),
      .ready_o  (req_ready_o[i]),
      .v_o      (fifo_v[i]),
      .data_o   (fifo_head[i]),
      .yumi_i   (fifo_yumi[i])
    );

    assign fifo_yumi[i] = late_v && (grant_idx == rr_w_lp'(i));
  end

  // First non-empty buffer at or above the rr pointer, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!grant_found && fifo_v[rr_w_lp'(late_wb_rr_scan(int'(rr_r), k, num_req_p))]) begin
        grant_found = 1'b1;
        grant_idx   = rr_w_lp'(late_wb_rr_scan(int'(rr_r), k, num_req_p));
      end
    end
  end

  assign late_entry  = fifo_head[grant_idx];
  assign late_v      = reset_n_i & ~pipe_wb_v_i & grant_found;
  assign req_grant_o = fifo_yumi;

  always_comb begin
    rf_w_v_o    = 1'b0;
    rf_w_addr_o = late_entry.rd_addr;
    rf_w_data_o = late_entry.rd_data;
    if (reset_n_i && pipe_wb_v_i) begin
      rf_w_v_o    = 1'b1;
      rf_w_addr_o = pipe_wb_addr_i;
      rf_w_data_o = pipe_wb_data_i;
    end else if (late_v) begin
      rf_w_v_o = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle re-allocation keeps the bit
  always_comb begin
    pending_n = pending_r;
    if (late_v)
      pending_n[late_entry.rd_addr] = 1'b0;
    if (alloc_v_i && (alloc_addr_i != '0))
      pending_n[alloc_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_r      <= '0;
      pending_r <= '0;
    end else begin
      pending_r <= pending_n;
      if (late_v)
        rr_r <= rr_w_lp'(late_wb_rr_next(int'(grant_idx), num_req_p));
    end
  end

  assign pending_o = pending_r;

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    late_v |-> (pending_r[late_entry.rd_addr] || (late_entry.rd_addr == '0)));
`endif

endmodule
